// File: rtl/ram_stream_loader.sv
// ram_stream_loader
//   Write-side front end for a 2**ADDR_W x DATA_W RAM. Owns the RAM write
//   port. When idle, CPU writes pass straight through to the RAM. On request,
//   it fills a region of sequential addresses, one word per clock. The fill
//   data is either a constant (CLEAR) or words taken from a valid/ready
//   stream (LOAD).
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   start_clear, start_load    operation requests, sampled only in IDLE
//   base_addr, length          region start and word count (0..2**ADDR_W)
//   s_data, s_valid, s_ready   input word stream
//   cpu_in, cpu_load,          CPU write port
//     cpu_address
//   ram_in, ram_load,          RAM write port
//     ram_address
//   busy                       high while a CLEAR or LOAD is running
//   done                       one-cycle pulse when an operation finishes
//   cpu_blocked                registered pulse for each dropped CPU write
//   word_count                 words written in current/last operation
//
// Handshake: a stream word transfers on any rising edge where
// s_valid & s_ready is high. s_ready is high only in LOAD. s_ready does not
// depend on s_valid. The producer holds s_data stable while s_valid is high
// and s_ready is low.
module ram_stream_loader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_clear,
  input  logic              start_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] cpu_in,
  input  logic              cpu_load,
  input  logic [ADDR_W-1:0] cpu_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic              busy,
  output logic              done,
  output logic              cpu_blocked,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              cpu_blocked_q, cpu_blocked_d;
  logic              write_word;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    word_count_d  = word_count_q;
    write_word    = 1'b0;
    ram_in        = cpu_in;
    ram_load      = cpu_load;
    ram_address   = cpu_address;
    s_ready       = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // CLEAR takes priority when both starts arrive together.
        if (start_clear || start_load) begin
          addr_d       = base_addr;
          remaining_d  = length;
          word_count_d = '0;
          if (length == '0)      state_d = ST_DONE;
          else if (start_clear)  state_d = ST_CLEAR;
          else                   state_d = ST_LOAD;
        end
      end
      ST_CLEAR: begin
        busy        = 1'b1;
        ram_in      = CLEAR_VALUE;
        ram_load    = 1'b1;
        ram_address = addr_q;
        write_word  = 1'b1;
      end
      ST_LOAD: begin
        busy        = 1'b1;
        s_ready     = 1'b1;
        ram_in      = s_data;
        ram_load    = s_valid;
        ram_address = addr_q;
        write_word  = s_valid;
      end
      default: begin
        // ST_DONE: CPU pass-through is already active; start requests are ignored.
        done    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    if (write_word) begin
      // The address wraps naturally modulo 2**ADDR_W.
      addr_d       = addr_q + 1'b1;
      remaining_d  = remaining_q - 1'b1;
      word_count_d = word_count_q + 1'b1;
      if (remaining_q == {{ADDR_W{1'b0}}, 1'b1}) state_d = ST_DONE;
    end

    cpu_blocked_d = busy & cpu_load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      word_count_q  <= '0;
      cpu_blocked_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      word_count_q  <= word_count_d;
      cpu_blocked_q <= cpu_blocked_d;
    end
  end

  assign cpu_blocked = cpu_blocked_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_ram_stream_loader.sv
// Directed bench for ram_stream_loader. A behavioural RAM16K model captures
// ram_in at ram_address on each rising edge where ram_load is high. Inputs
// change 1ns after a rising edge, and outputs are checked before the next edge.
module tb_ram_stream_loader;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_clear, start_load;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] cpu_in;
  logic              cpu_load;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] ram_in;
  logic              ram_load;
  logic [ADDR_W-1:0] ram_address;
  logic              busy, done, cpu_blocked;
  logic [ADDR_W:0]   word_count;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  int n_checks = 0;
  int n_fail   = 0;

  ram_stream_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_VALUE('0)) dut (
    .clk(clk), .reset(reset),
    .start_clear(start_clear), .start_load(start_load),
    .base_addr(base_addr), .length(length),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_address(cpu_address),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
    .busy(busy), .done(done), .cpu_blocked(cpu_blocked), .word_count(word_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // RAM16K model
  initial for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_load = 1'b1; cpu_address = a; cpu_in = d;
    tick();
    cpu_load = 1'b0;
  endtask

  task automatic start_op(input logic clr, input logic ld,
                          input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n);
    start_clear = clr; start_load = ld; base_addr = a; length = n;
    tick();
    start_clear = 1'b0; start_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_clear = 0; start_load = 0; base_addr = '0; length = '0;
    s_data = '0; s_valid = 0; cpu_in = '0; cpu_load = 0; cpu_address = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_blocked", cpu_blocked, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_word_count", word_count, 0);
    reset = 1'b0;
    tick();

    // IDLE pass-through
    cpu_load = 1; cpu_address = 14'h0123; cpu_in = 16'hBEEF;
    #1;
    chk("pt_ram_load", ram_load, 1);
    chk("pt_ram_address", ram_address, 32'h0123);
    chk("pt_ram_in", ram_in, 32'hBEEF);
    tick();
    cpu_load = 0;
    chk("pt_mem", mem[14'h0123], 32'hBEEF);

    // CLEAR with address wrap
    cpu_write(14'h3FFE, 16'hAAAA);
    cpu_write(14'h3FFF, 16'hAAAA);
    cpu_write(14'h0000, 16'hAAAA);
    cpu_write(14'h0001, 16'hAAAA);
    cpu_write(14'h0002, 16'hAAAA);
    start_op(1, 0, 14'h3FFE, 15'd4);
    chk("clr_busy", busy, 1);
    chk("clr_addr0", ram_address, 32'h3FFE);
    chk("clr_load", ram_load, 1);
    chk("clr_in", ram_in, 0);
    tick();
    chk("clr_addr1", ram_address, 32'h3FFF);
    tick();
    chk("clr_addr2", ram_address, 32'h0000);
    tick();
    chk("clr_addr3", ram_address, 32'h0001);
    tick();
    chk("clr_done", done, 1);
    chk("clr_busy_done", busy, 0);
    chk("clr_word_count", word_count, 4);
    tick();
    chk("clr_done_once", done, 0);
    chk("clr_wc_hold", word_count, 4);
    chk("clr_m3ffe", mem[14'h3FFE], 0);
    chk("clr_m3fff", mem[14'h3FFF], 0);
    chk("clr_m0000", mem[14'h0000], 0);
    chk("clr_m0001", mem[14'h0001], 0);
    chk("clr_m0002", mem[14'h0002], 32'hAAAA);

    // LOAD with a stalled stream
    start_op(0, 1, 14'h0100, 15'd3);
    chk("ld_s_ready", s_ready, 1);
    chk("ld_wc_start", word_count, 0);
    s_valid = 1; s_data = 16'h1111;
    tick();
    s_valid = 0; s_data = 16'hDEAD;
    #1;
    chk("ld_stall_load", ram_load, 0);
    tick();
    s_valid = 1; s_data = 16'h2222;
    tick();
    s_data = 16'h3333;
    tick();
    s_data = 16'h9999;   // extra word must not be consumed
    #1;
    chk("ld_s_ready_after", s_ready, 0);
    chk("ld_done", done, 1);
    chk("ld_word_count", word_count, 3);
    tick();
    s_valid = 0;
    chk("ld_m100", mem[14'h0100], 32'h1111);
    chk("ld_m101", mem[14'h0101], 32'h2222);
    chk("ld_m102", mem[14'h0102], 32'h3333);
    chk("ld_m103", mem[14'h0103], 0);

    // Both starts together: CLEAR wins
    cpu_write(14'h0200, 16'h5555);
    cpu_write(14'h0201, 16'h5555);
    start_op(1, 1, 14'h0200, 15'd2);
    chk("both_busy", busy, 1);
    chk("both_s_ready0", s_ready, 0);
    chk("both_ram_in", ram_in, 0);
    tick();
    chk("both_s_ready1", s_ready, 0);
    tick();
    chk("both_done", done, 1);
    tick();
    chk("both_m200", mem[14'h0200], 0);
    chk("both_m201", mem[14'h0201], 0);

    // Zero length: straight to DONE, no writes
    start_op(0, 1, 14'h0500, 15'd0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_ram_load", ram_load, 0);
    chk("zero_wc", word_count, 0);
    tick();
    chk("zero_done_once", done, 0);

    // CPU write while busy is dropped and flagged
    start_op(0, 1, 14'h0300, 15'd1);
    cpu_load = 1; cpu_address = 14'h0300; cpu_in = 16'h7777;
    #1;
    chk("blk_ram_load", ram_load, 0);
    tick();
    cpu_load = 0;
    chk("blk_pulse", cpu_blocked, 1);
    chk("blk_mem", mem[14'h0300], 0);
    tick();
    chk("blk_pulse_end", cpu_blocked, 0);
    s_valid = 1; s_data = 16'h4444;
    tick();
    s_valid = 0;
    chk("blk_done", done, 1);
    tick();
    chk("blk_mem_load", mem[14'h0300], 32'h4444);

    // Reset mid-LOAD
    start_op(0, 1, 14'h0400, 15'd5);
    s_valid = 1; s_data = 16'h00A1;
    tick();
    s_data = 16'h00A2;
    tick();
    s_valid = 0; reset = 1;
    tick();
    reset = 0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_s_ready", s_ready, 0);
    chk("mrst_wc", word_count, 0);
    tick();
    chk("mrst_no_done", done, 0);
    chk("mrst_m400", mem[14'h0400], 32'h00A1);
    chk("mrst_m401", mem[14'h0401], 32'h00A2);
    chk("mrst_m402", mem[14'h0402], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
